vga_scan_driver: RTL and testbench
==================================

Name: vga_scan_driver

Overview:
- Raster timing generator and registered VGA output stage for the 640x480@60 Hz display path.
- Sits directly upstream of the frame/sprite renderers: drives the pixel coordinate (o_x, o_y) they consume, takes their combinational 24-bit colour back, and registers it onto the DAC pins with matching sync and blank.
- Also provides frame-level strobes so the game logic can update state during vertical blank.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
i_clk  in  1  pixel clock, 25 MHz nominal
i_rst  in  1  asynchronous reset, active-high
i_rgb  in  24  colour for current (o_x, o_y), {R[23:16], G[15:8], B[7:0]}, combinational from downstream renderer
o_x  out  10  current visible column, 0..H_ACTIVE-1
o_y  out  9  current visible row, 0..V_ACTIVE-1
o_active  out  1  counters inside visible area
o_vga_r  out  8  registered red
o_vga_g  out  8  registered green
o_vga_b  out  8  registered blue
o_vga_hs  out  1  horizontal sync, active-low, registered
o_vga_vs  out  1  vertical sync, active-low, registered
o_vga_blank_n  out  1  registered, 1 = visible pixel
o_vga_sync_n  out  1  constant 0 (no sync-on-green)
o_frame_start  out  1  one-cycle pulse, registered
o_vblank  out  1  counters in line V_ACTIVE or later

Behaviour:
- Reset is asynchronous and active-high: any assertion immediately forces all state to reset values, including mid-line/mid-frame. Release resumes counting from (0,0) on the next rising edge.
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of H_* = 800.
  - v_cnt runs 0..V_TOTAL-1, where V_TOTAL = sum of V_* = 525.
  - h_cnt increments every clock and wraps to 0 after H_TOTAL-1.
  - v_cnt increments only on the h wrap, and wraps to 0 after V_TOTAL-1 coincident with the h wrap.
  - Reset value of both counters: 0.
- Line layout in h order: active [0, H_ACTIVE-1], front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], back porch. Vertical layout uses the same order on v_cnt.
- Combinational outputs (same cycle as counters):
  - o_active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - o_x = h_cnt[9:0] when h_cnt < H_ACTIVE, else 0.
  - o_y = v_cnt[8:0] when v_cnt < V_ACTIVE, else 0.
  - o_vblank = (v_cnt >= V_ACTIVE).
  - Reset values: o_x = 0, o_y = 0, o_active = 1, o_vblank = 0.
- Registered output stage, latency 1 clock from counter value to pins:
  - o_vga_hs / o_vga_vs = low iff h_cnt / v_cnt was in its sync window on the previous cycle.
  - o_vga_blank_n = previous o_active.
  - RGB = previous i_rgb when previous o_active, else 0 (forced black in blanking).
  - Reset values: o_vga_hs = 1, o_vga_vs = 1, o_vga_blank_n = 0, RGB = 0.
- o_frame_start: registered; high for exactly one cycle, aligned with the pins presenting pixel (0,0), i.e. one cycle after counters = (0,0). Reset value 0. It does not fire for the first frame after reset release; the first pulse comes at the first wrap.
- i_rgb is sampled only on the clock edge, so downstream combinational depth must settle within one pixel period.
- Vsync edges occur at h_cnt = 0 boundaries; hsync is unaffected by the vertical position.

Test Plan:
- Reset: hold i_rst high for 3 clocks, assert again asynchronously mid-line at h_cnt = 300 -> outputs immediately hs = 1, vs = 1, blank_n = 0, RGB = 0, o_x = 0, o_y = 0; after release o_x = 0, 1, 2 on successive cycles.
- Hsync timing: count from release -> o_vga_hs low for exactly 96 clocks, first low on cycle 657 (counter 656 + 1 latency); line period 800 clocks, measured edge to edge.
- Vsync and frame: o_vga_vs low for exactly 1600 clocks (2 lines), starting 1 cycle after counters = (0,490); o_frame_start first pulses 420001 cycles after release, then every 420000.
- Colour pass-through: drive i_rgb = 24'hFF8000 only when o_x = 5, o_y = 0 -> next cycle o_vga_r = 8'hFF, o_vga_g = 8'h80, o_vga_b = 8'h00, blank_n = 1; neighbouring pixels read 0.
- Blank forcing: drive i_rgb = 24'hFFFFFF constantly -> RGB = 0 and blank_n = 0 whenever the previous h_cnt >= 640 or v_cnt >= 480; o_vblank high for exactly 45 × 800 = 36000 clocks per frame.
- Coordinate range: over one full frame, o_x never exceeds 639 and o_y never exceeds 479; o_active is high for exactly 307200 cycles.

Source files
------------

// File: rtl/vga_scan_driver_if.sv
// Pixel-side bundle between the raster driver, the renderers and the DAC pins.
// The master modport is the driver's view; the slave modport is the renderer/pin side.
interface vga_scan_driver_if;
  logic [23:0] i_rgb;
  logic [9:0]  o_x;
  logic [8:0]  o_y;
  logic        o_active;
  logic        o_vblank;
  logic        o_frame_start;
  logic [7:0]  o_vga_r;
  logic [7:0]  o_vga_g;
  logic [7:0]  o_vga_b;
  logic        o_vga_hs;
  logic        o_vga_vs;
  logic        o_vga_blank_n;
  logic        o_vga_sync_n;

  modport master (
    input  i_rgb,
    output o_x, o_y, o_active, o_vblank, o_frame_start,
    output o_vga_r, o_vga_g, o_vga_b,
    output o_vga_hs, o_vga_vs, o_vga_blank_n, o_vga_sync_n
  );

  modport slave (
    output i_rgb,
    input  o_x, o_y, o_active, o_vblank, o_frame_start,
    input  o_vga_r, o_vga_g, o_vga_b,
    input  o_vga_hs, o_vga_vs, o_vga_blank_n, o_vga_sync_n
  );
endinterface

// File: rtl/vga_scan_driver.sv
// Raster counters for 640x480@60 plus a one-clock registered VGA pin stage.
// Coordinates go out combinationally; colour comes back and is latched with sync/blank.
module vga_scan_driver #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  vga_scan_driver_if.master    bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_L   = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST_L  = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_LO = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_HI = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT_L   = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST_L  = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SYNC_LO = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_HI = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic        h_wrap, frame_wrap;
  logic        h_vis, v_vis, active, in_hsync, in_vsync;

  logic        hs_q, vs_q, blank_n_q;
  logic [23:0] rgb_q;
  logic        wrap_q, frame_start_q;

  always_comb begin
    h_wrap     = (h_cnt_q == H_LAST_L);
    frame_wrap = h_wrap && (v_cnt_q == V_LAST_L);
    h_cnt_d    = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d    = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST_L) ? 10'd0 : v_cnt_q + 10'd1;
    end
  end

  always_comb begin
    h_vis    = (h_cnt_q < H_ACT_L);
    v_vis    = (v_cnt_q < V_ACT_L);
    active   = h_vis && v_vis;
    in_hsync = (h_cnt_q >= H_SYNC_LO) && (h_cnt_q < H_SYNC_HI);
    in_vsync = (v_cnt_q >= V_SYNC_LO) && (v_cnt_q < V_SYNC_HI);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      rgb_q         <= 24'd0;
      wrap_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hs_q          <= ~in_hsync;
      vs_q          <= ~in_vsync;
      blank_n_q     <= active;
      // Blanking is forced black regardless of what the renderer drives.
      rgb_q         <= active ? bus.i_rgb : 24'd0;
      // Two-stage so the pulse lines up with pixel (0,0) reaching the pins.
      wrap_q        <= frame_wrap;
      frame_start_q <= wrap_q;
    end
  end

  assign bus.o_x           = h_vis ? h_cnt_q : 10'd0;
  assign bus.o_y           = v_vis ? v_cnt_q[8:0] : 9'd0;
  assign bus.o_active      = active;
  assign bus.o_vblank      = ~v_vis;
  assign bus.o_vga_r       = rgb_q[23:16];
  assign bus.o_vga_g       = rgb_q[15:8];
  assign bus.o_vga_b       = rgb_q[7:0];
  assign bus.o_vga_hs      = hs_q;
  assign bus.o_vga_vs      = vs_q;
  assign bus.o_vga_blank_n = blank_n_q;
  assign bus.o_vga_sync_n  = 1'b0;
  assign bus.o_frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver: a full-size instance for line timing and a shrunken
// instance for whole-frame behaviour, both against an arithmetic raster model.
module tb_vga_scan_driver;
  localparam int SHA = 64, SHF = 4, SHS = 12, SHB = 8;
  localparam int SVA = 48, SVF = 2, SVS = 2, SVB = 4;
  localparam int S_FRAME = (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);
  localparam int T_END = 3 * S_FRAME + 5;

  typedef struct {
    int x; int y; bit active; bit vblank; bit hsync; bit vsync;
  } phase_t;

  typedef struct {
    logic [9:0] x; logic [8:0] y; logic active; logic vblank; logic fs;
    logic [7:0] r; logic [7:0] g; logic [7:0] b;
    logic hs; logic vs; logic blank_n; logic sync_n;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_scan_driver_if bus_full ();
  vga_scan_driver_if bus_small ();

  vga_scan_driver u_full (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_full.master)
  );

  vga_scan_driver #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) u_small (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_small.master)
  );

  int          geo [2][8];
  logic [23:0] cur_rgb [2];
  int          n_checks = 0;
  int          n_fail = 0;

  int hs_low_cnt, hs_first_fall, hs_second_fall;
  logic hs_prev;
  int act_cnt, vblank_cnt, vs_low_cnt, fs_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int h_total(input int i);
    return geo[i][0] + geo[i][1] + geo[i][2] + geo[i][3];
  endfunction

  function automatic int f_total(input int i);
    return h_total(i) * (geo[i][4] + geo[i][5] + geo[i][6] + geo[i][7]);
  endfunction

  // Position of the raster t clocks after reset release, straight from the line/frame layout.
  function automatic phase_t phase(input int i, input int t);
    phase_t p;
    int ht, vt, h, v, hs0, vs0;
    ht  = h_total(i);
    vt  = f_total(i) / ht;
    h   = t % ht;
    v   = (t / ht) % vt;
    hs0 = geo[i][0] + geo[i][1];
    vs0 = geo[i][4] + geo[i][5];
    p.active = (h < geo[i][0]) && (v < geo[i][4]);
    p.x      = (h < geo[i][0]) ? h : 0;
    p.y      = (v < geo[i][4]) ? v : 0;
    p.vblank = (v >= geo[i][4]);
    p.hsync  = (h >= hs0) && (h < hs0 + geo[i][2]);
    p.vsync  = (v >= vs0) && (v < vs0 + geo[i][6]);
    return p;
  endfunction

  function automatic obs_t get_obs(input int i);
    obs_t o;
    if (i == 0) begin
      o.x = bus_full.o_x; o.y = bus_full.o_y; o.active = bus_full.o_active;
      o.vblank = bus_full.o_vblank; o.fs = bus_full.o_frame_start;
      o.r = bus_full.o_vga_r; o.g = bus_full.o_vga_g; o.b = bus_full.o_vga_b;
      o.hs = bus_full.o_vga_hs; o.vs = bus_full.o_vga_vs;
      o.blank_n = bus_full.o_vga_blank_n; o.sync_n = bus_full.o_vga_sync_n;
    end else begin
      o.x = bus_small.o_x; o.y = bus_small.o_y; o.active = bus_small.o_active;
      o.vblank = bus_small.o_vblank; o.fs = bus_small.o_frame_start;
      o.r = bus_small.o_vga_r; o.g = bus_small.o_vga_g; o.b = bus_small.o_vga_b;
      o.hs = bus_small.o_vga_hs; o.vs = bus_small.o_vga_vs;
      o.blank_n = bus_small.o_vga_blank_n; o.sync_n = bus_small.o_vga_sync_n;
    end
    return o;
  endfunction

  // t = 0 means counters at (0,0) with the pin stage still holding reset values.
  task automatic check_cycle(input int i, input int t);
    phase_t p, q;
    obs_t o;
    logic [23:0] e_rgb;
    logic e_hs, e_vs, e_bn, e_fs;
    p = phase(i, t);
    o = get_obs(i);
    if (t == 0) begin
      e_hs = 1'b1; e_vs = 1'b1; e_bn = 1'b0; e_rgb = 24'd0; e_fs = 1'b0;
    end else begin
      q = phase(i, t - 1);
      e_hs  = ~q.hsync;
      e_vs  = ~q.vsync;
      e_bn  = q.active;
      e_rgb = q.active ? cur_rgb[i] : 24'd0;
      e_fs  = (t > f_total(i)) && (t % f_total(i) == 1);
    end
    check($sformatf("x[%0d]@%0d", i, t), 32'(o.x), 32'(p.x));
    check($sformatf("y[%0d]@%0d", i, t), 32'(o.y), 32'(p.y));
    check($sformatf("active[%0d]@%0d", i, t), 32'(o.active), 32'(p.active));
    check($sformatf("vblank[%0d]@%0d", i, t), 32'(o.vblank), 32'(p.vblank));
    check($sformatf("hs[%0d]@%0d", i, t), 32'(o.hs), 32'(e_hs));
    check($sformatf("vs[%0d]@%0d", i, t), 32'(o.vs), 32'(e_vs));
    check($sformatf("blank_n[%0d]@%0d", i, t), 32'(o.blank_n), 32'(e_bn));
    check($sformatf("rgb[%0d]@%0d", i, t), {8'd0, o.r, o.g, o.b}, 32'(e_rgb));
    check($sformatf("fs[%0d]@%0d", i, t), 32'(o.fs), 32'(e_fs));
    check($sformatf("sync_n[%0d]@%0d", i, t), 32'(o.sync_n), 32'd0);
  endtask

  task automatic drive_rgb(input int t);
    phase_t p;
    p = phase(0, t);
    cur_rgb[0] = (p.active && p.x == 5 && p.y == 0) ? 24'hFF8000 : 24'h000000;
    if ((t / S_FRAME) == 1) cur_rgb[1] = 24'hFFFFFF;
    else                    cur_rgb[1] = 24'($urandom);
    bus_full.i_rgb  = cur_rgb[0];
    bus_small.i_rgb = cur_rgb[1];
  endtask

  task automatic tally(input int t);
    obs_t o0, o1;
    o0 = get_obs(0);
    o1 = get_obs(1);
    if (t <= 1600) begin
      if (o0.hs == 1'b0) hs_low_cnt++;
      if (hs_prev == 1'b1 && o0.hs == 1'b0) begin
        if (hs_first_fall == 0) hs_first_fall = t;
        else if (hs_second_fall == 0) hs_second_fall = t;
      end
      hs_prev = o0.hs;
    end
    if (t <= S_FRAME) begin
      if (o1.active == 1'b1) act_cnt++;
      if (o1.vblank == 1'b1) vblank_cnt++;
      if (o1.vs == 1'b0) vs_low_cnt++;
    end
    if (o1.fs == 1'b1) fs_cnt++;
  endtask

  initial begin
    geo[0] = '{640, 16, 96, 48, 480, 10, 2, 33};
    geo[1] = '{SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB};
    cur_rgb[0] = 24'd0;
    cur_rgb[1] = 24'd0;
    bus_full.i_rgb  = 24'd0;
    bus_small.i_rgb = 24'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) check_cycle(i, 0);

    // First run up to mid-line, then hit reset asynchronously.
    rst = 1'b0;
    drive_rgb(0);
    for (int t = 1; t <= 300; t++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) check_cycle(i, t);
      drive_rgb(t);
    end
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) check_cycle(i, 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) check_cycle(i, 0);

    hs_low_cnt = 0; hs_first_fall = 0; hs_second_fall = 0; hs_prev = 1'b1;
    act_cnt = 0; vblank_cnt = 0; vs_low_cnt = 0; fs_cnt = 0;
    rst = 1'b0;
    drive_rgb(0);
    for (int t = 1; t <= T_END; t++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) check_cycle(i, t);
      tally(t);
      if (t == 6) begin
        check("px5_r", 32'(bus_full.o_vga_r), 32'hFF);
        check("px5_g", 32'(bus_full.o_vga_g), 32'h80);
        check("px5_b", 32'(bus_full.o_vga_b), 32'h00);
        check("px5_blank_n", 32'(bus_full.o_vga_blank_n), 32'd1);
      end
      drive_rgb(t);
    end

    check("hs_low_total", 32'(hs_low_cnt), 32'(2 * 96));
    check("hs_first_fall", 32'(hs_first_fall), 32'd657);
    check("hs_period", 32'(hs_second_fall - hs_first_fall), 32'd800);
    check("active_per_frame", 32'(act_cnt), 32'(SHA * SVA));
    check("vblank_per_frame", 32'(vblank_cnt), 32'((SVF + SVS + SVB) * (SHA + SHF + SHS + SHB)));
    check("vs_low_per_frame", 32'(vs_low_cnt), 32'(SVS * (SHA + SHF + SHS + SHB)));
    check("frame_start_count", 32'(fs_cnt), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
